// File: rtl/frame_checker_8b.sv
// -----------------------------------------------------------------------------
// frame_checker_8b
//
// Purpose:
//   Hunts a byte stream for frames of the form
//     SYNC_BYTE, LEN (1..255), LEN payload bytes, CHK
//   and forwards the payload bytes one cycle after they are accepted. CHK must
//   equal the modulo-256 sum of LEN and every payload byte. A good checksum
//   gives a one-cycle frame_ok pulse. A bad checksum or a zero LEN gives a
//   one-cycle frame_err pulse. frame_err pulses are counted in a saturating
//   8-bit counter.
//
// Handshake:
//   din_en qualifies din. A byte is accepted on a rising clk edge only when
//   din_en=1. There is no backpressure. On cycles with din_en=0 the state,
//   count and sum hold, and every pulse output (dout_vld, sof, eof, frame_ok,
//   frame_err) is 0 on the following cycle.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-low reset
//   din[7:0]   in   byte stream
//   din_en     in   din qualifier
//   dout[7:0]  out  payload byte (registered; holds last payload byte)
//   dout_vld   out  dout valid strobe
//   sof        out  first payload byte of a frame (only with dout_vld)
//   eof        out  last payload byte of a frame (only with dout_vld)
//   frame_ok   out  one-cycle pulse: checksum matched
//   frame_err  out  one-cycle pulse: checksum mismatch or LEN == 0
//   busy       out  high whenever the FSM is not hunting
//   err_cnt    out  number of frame_err pulses, saturating at 255
//   state_dbg  out  current FSM state (0 HUNT, 1 LEN, 2 PAYLOAD, 3 CHECK)
// -----------------------------------------------------------------------------
module frame_checker_8b #(
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       din_en,
   output logic [7:0] dout,
   output logic       dout_vld,
   output logic       sof,
   output logic       eof,
   output logic       frame_ok,
   output logic       frame_err,
   output logic       busy,
   output logic [7:0] err_cnt,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      S_HUNT    = 2'd0,
      S_LEN     = 2'd1,
      S_PAYLOAD = 2'd2,
      S_CHECK   = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] count_q, count_d;
   logic [7:0] sum_q, sum_d;
   logic       first_q, first_d;
   logic [7:0] dout_q, dout_d;
   logic       dout_vld_q, dout_vld_d;
   logic       sof_q, sof_d;
   logic       eof_q, eof_d;
   logic       frame_ok_q, frame_ok_d;
   logic       frame_err_q, frame_err_d;
   logic       busy_q, busy_d;
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      sum_d       = sum_q;
      first_d     = first_q;
      dout_d      = dout_q;
      dout_vld_d  = 1'b0;
      sof_d       = 1'b0;
      eof_d       = 1'b0;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;

      if (din_en) begin
         case (state_q)
            S_HUNT: begin
               if (din == SYNC_BYTE) begin
                  state_d = S_LEN;
               end
            end
            S_LEN: begin
               // SYNC_BYTE is treated as data here; resync happens only in HUNT.
               if (din == 8'd0) begin
                  frame_err_d = 1'b1;
                  state_d     = S_HUNT;
               end else begin
                  count_d = din;
                  sum_d   = din;
                  first_d = 1'b1;
                  state_d = S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               dout_d     = din;
               dout_vld_d = 1'b1;
               sof_d      = first_q;
               eof_d      = (count_q == 8'd1);
               first_d    = 1'b0;
               sum_d      = sum_q + din;
               count_d    = count_q - 8'd1;
               if (count_q == 8'd1) begin
                  state_d = S_CHECK;
               end
            end
            S_CHECK: begin
               frame_ok_d  = (din == sum_q);
               frame_err_d = (din != sum_q);
               state_d     = S_HUNT;
            end
            default: begin
               state_d = S_HUNT;
            end
         endcase
      end

      // busy is registered from the next state so it tracks state_q exactly.
      busy_d = (state_d != S_HUNT);

      err_cnt_d = err_cnt_q;
      if (frame_err_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_HUNT;
         count_q     <= 8'd0;
         sum_q       <= 8'd0;
         first_q     <= 1'b0;
         dout_q      <= 8'd0;
         dout_vld_q  <= 1'b0;
         sof_q       <= 1'b0;
         eof_q       <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
         err_cnt_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         sum_q       <= sum_d;
         first_q     <= first_d;
         dout_q      <= dout_d;
         dout_vld_q  <= dout_vld_d;
         sof_q       <= sof_d;
         eof_q       <= eof_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign dout      = dout_q;
   assign dout_vld  = dout_vld_q;
   assign sof       = sof_q;
   assign eof       = eof_q;
   assign frame_ok  = frame_ok_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;
   assign err_cnt   = err_cnt_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_frame_checker_8b.sv
// -----------------------------------------------------------------------------
// tb_frame_checker_8b
//
// Bench for frame_checker_8b. It builds whole frames (sync, length, payload
// queue, checksum) and predicts the outputs from the frame contents: payload
// byte i is echoed one cycle after acceptance, with sof on i==0 and eof on
// i==LEN-1. After CHK, frame_ok is expected if CHK equals
// (LEN + sum of payload) mod 256. The error count is a saturating integer.
// Directed frames come first, then randomized frames with idle gaps, then
// saturation of err_cnt.
// -----------------------------------------------------------------------------
module tb_frame_checker_8b;

   localparam logic [7:0] SYNC = 8'hA5;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] din = 8'd0;
   logic       din_en = 1'b0;
   logic [7:0] dout;
   logic       dout_vld, sof, eof, frame_ok, frame_err, busy;
   logic [7:0] err_cnt;
   logic [1:0] state_dbg;

   always #5 clk = ~clk;

   frame_checker_8b #(.SYNC_BYTE(SYNC)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_en    (din_en),
      .dout      (dout),
      .dout_vld  (dout_vld),
      .sof       (sof),
      .eof       (eof),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .busy      (busy),
      .err_cnt   (err_cnt),
      .state_dbg (state_dbg)
   );

   // ---------------- model state ----------------
   int         n_checks = 0;
   int         n_pass = 0;
   int         model_err_cnt = 0;
   logic       model_busy = 1'b0;
   logic [7:0] pl_q[$];
   int         forced_gap_at = -1;
   int         forced_gap_len = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: drive inputs, wait for the edge, then check the outputs
   // against the expected values for this byte.
   task automatic cycle(input logic [7:0] b, input logic en, input logic e_vld,
                        input logic [7:0] e_dout, input logic e_sof, input logic e_eof,
                        input logic e_ok, input logic e_err);
      din    = b;
      din_en = en;
      @(posedge clk);
      #1;
      if (e_err) model_err_cnt = (model_err_cnt >= 255) ? 255 : model_err_cnt + 1;
      check("dout_vld", {31'd0, dout_vld}, {31'd0, e_vld});
      if (e_vld) check("dout", {24'd0, dout}, {24'd0, e_dout});
      check("sof", {31'd0, sof}, {31'd0, e_sof});
      check("eof", {31'd0, eof}, {31'd0, e_eof});
      check("frame_ok", {31'd0, frame_ok}, {31'd0, e_ok});
      check("frame_err", {31'd0, frame_err}, {31'd0, e_err});
      check("ok_err_excl", {31'd0, frame_ok & frame_err}, 32'd0);
      check("busy", {31'd0, busy}, {31'd0, model_busy});
      check("err_cnt", {24'd0, err_cnt}, model_err_cnt);
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cycle(8'($urandom_range(0, 255)), 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic between(input int pos, input int max_gap);
      if (pos == forced_gap_at) idle(forced_gap_len);
      else if (max_gap > 0) idle($urandom_range(0, max_gap));
   endtask

   task automatic junk(input logic [7:0] b);
      model_busy = 1'b0;
      cycle(b, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Sends SYNC, len, pl_q[0..len-1], then CHK = sum + chk_delta.
   task automatic send_frame(input int len, input int chk_delta, input int max_gap);
      int         sum;
      logic [7:0] chk;
      logic       good;
      model_busy = 1'b1;
      cycle(SYNC, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      between(0, max_gap);
      if (len == 0) begin
         model_busy = 1'b0;
         cycle(8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
         cycle(8'(len), 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         between(1, max_gap);
         sum = len;
         for (int i = 0; i < len; i++) begin
            cycle(pl_q[i], 1'b1, 1'b1, pl_q[i], i == 0, i == len - 1, 1'b0, 1'b0);
            sum += int'(pl_q[i]);
            between(2 + i, max_gap);
         end
         chk  = 8'((sum + chk_delta) % 256);
         good = (int'(chk) == (sum % 256));
         model_busy = 1'b0;
         cycle(chk, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, good, !good);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dout"}, {24'd0, dout}, 32'd0);
      check({tag, "_vld"}, {31'd0, dout_vld}, 32'd0);
      check({tag, "_sof_eof"}, {30'd0, sof, eof}, 32'd0);
      check({tag, "_ok_err"}, {30'd0, frame_ok, frame_err}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_err_cnt"}, {24'd0, err_cnt}, 32'd0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int         len;
      logic [7:0] b;

      // Reset state
      #1;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;

      // Good frame A5 03 10 20 30 63
      pl_q = {8'h10, 8'h20, 8'h30};
      send_frame(3, 0, 0);
      // Same frame with CHK=64
      send_frame(3, 1, 0);
      idle(2);

      // 00 FF A5 00 A5 01 A5 A6
      junk(8'h00);
      junk(8'hFF);
      send_frame(0, 0, 0);
      pl_q = {8'hA5};
      send_frame(1, 0, 0);

      // A5 02 11 22 35 with a 3-cycle din_en gap between 11 and 22
      pl_q = {8'h11, 8'h22};
      forced_gap_at  = 2;
      forced_gap_len = 3;
      send_frame(2, 0, 0);
      forced_gap_at  = -1;

      // Back-to-back A5 01 07 08 A5 01 09 0A
      pl_q = {8'h07};
      send_frame(1, 0, 0);
      pl_q = {8'h09};
      send_frame(1, 0, 0);

      // Reset in the payload of a LEN=5 frame
      model_busy = 1'b1;
      cycle(SYNC, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(8'd5, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(8'h41, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 1'b0);
      din = 8'h42;
      rst = 1'b0;
      #1;
      check_all_zero("mid_rst");
      @(posedge clk);
      #1;
      check_all_zero("mid_rst_hold");
      rst = 1'b1;
      model_busy    = 1'b0;
      model_err_cnt = 0;
      pl_q = {8'h01, 8'h02, 8'h03};
      send_frame(3, 0, 0);

      // Randomized frames with junk and idle gaps
      for (int f = 0; f < 40; f++) begin
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
            b = 8'($urandom_range(0, 255));
            if (b == SYNC) b = 8'h5A;
            junk(b);
         end
         len = (f == 20) ? 255 : (($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 16)));
         pl_q = {};
         for (int i = 0; i < len; i++) begin
            pl_q.push_back(($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom_range(0, 255)));
         end
         send_frame(len, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 255)), 2);
         idle($urandom_range(0, 1));
      end

      // 260 bad frames saturate err_cnt
      for (int f = 0; f < 260; f++) begin
         if (f % 2 == 0) begin
            send_frame(0, 0, 0);
         end else begin
            pl_q = {8'($urandom_range(0, 255))};
            send_frame(1, int'($urandom_range(1, 255)), 0);
         end
      end
      check("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
      pl_q = {8'hA5, 8'h5A};
      send_frame(2, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, %0d/%0d", n_pass, n_checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/frame_checker_8b.md
FRAME_CHECKER_8B -- requirements
Module: frame_checker_8b

Interface
REQ-001 Parameter: SYNC_BYTE, 8'hA5, frame start marker.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: din  input  8  byte stream from the upstream 8-byte delay stage.
REQ-005 Port: din_en  input  1  din qualifier; tie high for a byte-per-clock stream.
REQ-006 Port: dout  output  8  payload byte, registered.
REQ-007 Port: dout_vld  output  1  dout valid strobe.
REQ-008 Port: sof  output  1  first payload byte; high only with dout_vld.
REQ-009 Port: eof  output  1  last payload byte; high only with dout_vld.
REQ-010 Port: frame_ok  output  1  one-cycle pulse for a good checksum.
REQ-011 Port: frame_err  output  1  one-cycle pulse for a bad checksum or zero length.
REQ-012 Port: busy  output  1  high whenever the state is not HUNT.
REQ-013 Port: err_cnt  output  8  count of frame_err pulses; saturates at 255.

Function
REQ-014 The frame format SHALL be SYNC_BYTE, LEN (1..255), then LEN payload bytes, then CHK.
REQ-015 CHK SHALL equal the modulo-256 sum of LEN and all payload bytes.
REQ-016 Only cycles with din_en=1 SHALL be accepted; with din_en=0, state, count and sum hold and all pulse outputs are 0.
REQ-017 The FSM SHALL have four states: HUNT, LEN, PAYLOAD and CHECK.
REQ-018 HUNT: an accepted din==SYNC_BYTE SHALL go to LEN; any other byte is discarded.
REQ-019 LEN: an accepted din==0 SHALL pulse frame_err and go to HUNT.
REQ-020 LEN: any other accepted byte SHALL load count=din and sum=din, then go to PAYLOAD.
REQ-021 PAYLOAD: each accepted byte SHALL drive dout=din with dout_vld=1 on the next cycle (latency 1), add din to sum and decrement count.
REQ-022 PAYLOAD: the accepted byte with count==1 SHALL go to CHECK.
REQ-023 sof SHALL mark the first payload byte and eof the byte with count==1; for LEN=1, sof and eof SHALL both be high on the same cycle.
REQ-024 Bytes equal to SYNC_BYTE inside LEN, PAYLOAD or CHECK SHALL be treated as data, with no resync.
REQ-025 CHECK: an accepted byte SHALL pulse frame_ok if din==sum, else frame_err, one cycle after acceptance; the next state is HUNT.
REQ-026 A SYNC_BYTE in the cycle immediately after CHK SHALL start a new frame; no idle gap is required between frames.
REQ-027 err_cnt SHALL increment on each frame_err pulse and hold at 255.
REQ-028 frame_ok and frame_err SHALL never be high in the same cycle.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 While rst=0, the block SHALL immediately force state=HUNT, count=0, sum=0 and every output to 0, including dout and err_cnt.
REQ-031 Reset asserted mid-frame SHALL abort the frame silently: no frame_err and no err_cnt change.
REQ-032 The first accepted byte after rst returns high SHALL be evaluated in HUNT.

Verification
REQ-033 Stream A5 03 10 20 30 63 (din_en=1) -> dout 10/20/30 on 3 consecutive cycles; sof with 10, eof with 30; frame_ok one cycle after 63; err_cnt stays 0.
REQ-034 Same frame with CHK=64 -> payload still emitted; frame_err pulse; err_cnt=1; busy falls the same cycle.
REQ-035 Stream 00 FF A5 00 A5 01 A5 A6 -> first two bytes ignored; frame_err for LEN=0; then a one-byte frame with payload A5 (sof=eof=1) and frame_ok.
REQ-036 Frame A5 02 11 22 35 with din_en low for 3 cycles between 11 and 22 -> exactly 2 dout_vld pulses, no output during the gap, frame_ok.
REQ-037 Back-to-back frames A5 01 07 08 A5 01 09 0A -> two frame_ok pulses, 4 cycles apart; dout 07 then 09.
REQ-038 rst low during the payload of a LEN=5 frame -> all outputs 0 immediately, no frame_err, next good frame gives frame_ok; 260 bad frames -> err_cnt=255.
